pipe_stage_reg: RTL

- Parametrised successor to the fixed-field inter-stage registers (IF/ID … MEM/WB).
- Carries one packed WIDTH-bit payload through DEPTH back-to-back register stages.
- Each stage has a valid bit; global freeze (stall) and flush (bubble insertion) act on all stages.
- Provides occupancy plus saturating stall/flush counters for pipeline debug.
- Instantiated between pipeline stages in place of hand-written per-field registers; callers pack and unpack their fields.

---
 rtl/pipe_stage_reg.sv | 119 +++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register.
// Carries one packed payload through DEPTH register stages, each with its own valid bit.
// A global flush inserts bubbles into every stage and a global freeze holds every stage.
// Saturating stall/flush counters and a live occupancy count are exported for debug.
module pipe_stage_reg #(
  parameter int unsigned          WIDTH       = 32,
  parameter int unsigned          DEPTH       = 1,
  parameter logic [WIDTH-1:0]     RESET_VAL   = '0,
  parameter bit                   ZERO_BUBBLE = 1'b1,
  parameter int unsigned          CNT_W       = 16
) (
  input  logic                        clk,
  input  logic                        rst_b,
  input  logic                        freeze,
  input  logic                        flush,
  input  logic                        in_valid,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            out_data,
  output logic [$clog2(DEPTH+1)-1:0]  occupancy,
  output logic [CNT_W-1:0]            stall_cycles,
  output logic [CNT_W-1:0]            flush_count
);

  localparam int unsigned      OccW   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  // Reject configurations that cannot form a pipeline.
  if (DEPTH == 0) begin : gen_bad_depth
    $error("pipe_stage_reg: DEPTH must be >= 1");
  end
  if (WIDTH == 0) begin : gen_bad_width
    $error("pipe_stage_reg: WIDTH must be >= 1");
  end

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic [OccW-1:0]  occ;

  // Stage next-state: flush beats freeze, freeze beats advance.
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      data_d[i] = data_q[i];
    end

    if (flush) begin
      valid_d = '0;
      if (ZERO_BUBBLE) begin
        for (int i = 0; i < DEPTH; i++) begin
          data_d[i] = RESET_VAL;
        end
      end
    end else if (!freeze) begin
      valid_d[0] = in_valid;
      data_d[0]  = (ZERO_BUBBLE && !in_valid) ? RESET_VAL : in_data;
      for (int i = 1; i < DEPTH; i++) begin
        valid_d[i] = valid_q[i-1];
        data_d[i]  = data_q[i-1];
      end
    end
  end

  // Saturating debug counters; a freeze that coincides with a flush is not a stall.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (flush) begin
      if (flush_q != CntMax) flush_d = flush_q + CntOne;
    end else if (freeze) begin
      if (stall_q != CntMax) stall_d = stall_q + CntOne;
    end
  end

  // Stage registers with asynchronous clear to RESET_VAL.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RESET_VAL;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  // Counter registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  // Popcount of the stage valid bits.
  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ = occ + OccW'(valid_q[i]);
    end
  end

  assign out_valid    = valid_q[DEPTH-1];
  assign out_data     = data_q[DEPTH-1];
  assign occupancy    = occ;
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule
